// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_ctrl (with helper cell full_adder)
//  Purpose  : Bit-serial adder. One 1-bit full_adder cell is stepped over a
//             WIDTH-bit operand pair, LSB first, one bit per clock, with a
//             carry flip-flop feeding each carry-out back as the next
//             carry-in. A start/busy/done handshake frames each operation.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH  operand/sum width in bits, 2..64 (default 8)
//  Ports
//    clk    in   1      clock, rising edge
//    rst_n  in   1      synchronous active-low reset
//    start  in   1      request, sampled only when not busy (IDLE or DONE)
//    a, b   in   WIDTH  operands, captured on the accepted start edge
//    cin    in   1      initial carry, captured on the accepted start edge
//    sub    in   1      subtract select (only with SERIAL_SUB_EN)
//    busy   out  1      high while bits are being processed
//    done   out  1      one-cycle pulse when s/cout have just been updated
//    s      out  WIDTH  registered sum, held until the next completion
//    cout   out  1      registered final carry, held until next completion
//  Build option
//    SERIAL_SUB_EN  adds the sub port; sub=1 computes a - b (cout=1: no
//                   borrow) by loading ~b and forcing the initial carry to 1.
// ============================================================================

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_ra;
    logic [WIDTH-1:0]   r_rb;
    // Only WIDTH-1 partial bits are stored: the final bit comes straight
    // from the adder on the last cycle and goes directly into r_s.
    logic [WIDTH-2:0]   r_rs;
    logic               r_cy;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_s;
    logic               r_cout;

    logic               w_fa_s;
    logic               w_fa_cout;
    logic [WIDTH-1:0]   w_shift;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_cy_load;
    logic               w_load;
    logic               w_run;
    logic               w_last;

    full_adder u_fa (
        .i_a (r_ra[0]),
        .i_b (r_rb[0]),
        .i_c (r_cy),
        .o_s (w_fa_s),
        .o_c (w_fa_cout)
    );

`ifdef SERIAL_SUB_EN
    // a - b == a + ~b + 1; the "+1" rides in on the initial carry.
    assign w_b_load  = sub ? ~b : b;
    assign w_cy_load = sub | cin;
`else
    assign w_b_load  = b;
    assign w_cy_load = cin;
`endif

    // Start is honoured in IDLE and in DONE (back-to-back), never in RUN.
    assign w_load  = start & ((r_state == c_ST_IDLE) | (r_state == c_ST_DONE));
    assign w_run   = (r_state == c_ST_RUN);
    assign w_last  = w_run & (r_cnt == c_CNT_LAST);
    assign w_shift = {w_fa_s, r_rs};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (start) w_state_next = c_ST_RUN;
            c_ST_RUN:  if (r_cnt == c_CNT_LAST) w_state_next = c_ST_DONE;
            c_ST_DONE: w_state_next = start ? c_ST_RUN : c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_ST_RUN:  busy = 1'b1;
            c_ST_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ra   <= '0;
            r_rb   <= '0;
            r_rs   <= '0;
            r_cy   <= 1'b0;
            r_cnt  <= '0;
            r_s    <= '0;
            r_cout <= 1'b0;
        end else if (w_load) begin
            r_ra  <= a;
            r_rb  <= w_b_load;
            r_cy  <= w_cy_load;
            r_cnt <= '0;
        end else if (w_run) begin
            r_rs  <= w_shift[WIDTH-1:1];
            r_cy  <= w_fa_cout;
            r_ra  <= r_ra >> 1;
            r_rb  <= r_rb >> 1;
            r_cnt <= r_cnt + 1'b1;
            // Outputs move only on the completion edge.
            if (w_last) begin
                r_s    <= w_shift;
                r_cout <= w_fa_cout;
            end
        end
    end

    assign s    = r_s;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder_ctrl
//  Purpose  : Self-checking bench for serial_adder_ctrl. Two instances
//             (WIDTH=8 and WIDTH=13) are driven with directed cases and a
//             randomized sweep; results are compared against a plain
//             arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    localparam int N_DUT = 2;
    localparam int W0    = 8;
    localparam int W1    = 13;
`ifdef SERIAL_SUB_EN
    localparam bit c_SUB_EN = 1'b1;
`else
    localparam bit c_SUB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start_v [N_DUT];
    logic [63:0] a_v     [N_DUT];
    logic [63:0] b_v     [N_DUT];
    logic        cin_v   [N_DUT];
    logic        sub_v   [N_DUT];
    logic        busy_v  [N_DUT];
    logic        done_v  [N_DUT];
    logic        cout_v  [N_DUT];
    logic [63:0] s_v     [N_DUT];

    wire          busy8, done8, cout8;
    wire [W0-1:0] s8;
    wire          busy13, done13, cout13;
    wire [W1-1:0] s13;

    serial_adder_ctrl #(.WIDTH(W0)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_v[0]),
        .a     (a_v[0][W0-1:0]),
        .b     (b_v[0][W0-1:0]),
        .cin   (cin_v[0]),
`ifdef SERIAL_SUB_EN
        .sub   (sub_v[0]),
`endif
        .busy  (busy8),
        .done  (done8),
        .s     (s8),
        .cout  (cout8)
    );

    serial_adder_ctrl #(.WIDTH(W1)) u_dut13 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_v[1]),
        .a     (a_v[1][W1-1:0]),
        .b     (b_v[1][W1-1:0]),
        .cin   (cin_v[1]),
`ifdef SERIAL_SUB_EN
        .sub   (sub_v[1]),
`endif
        .busy  (busy13),
        .done  (done13),
        .s     (s13),
        .cout  (cout13)
    );

    assign busy_v[0] = busy8;
    assign done_v[0] = done8;
    assign cout_v[0] = cout8;
    assign s_v[0]    = 64'(s8);
    assign busy_v[1] = busy13;
    assign done_v[1] = done13;
    assign cout_v[1] = cout13;
    assign s_v[1]    = 64'(s13);

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int k);
        return (k == 0) ? W0 : W1;
    endfunction

    // Reference: {cout, s} as a (w+1)-bit number.
    function automatic logic [63:0] ref_result(input int w, input logic [63:0] a, input logic [63:0] b,
                                               input logic cin, input logic sub);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        if (sub)
            return ((a >= b) ? (64'd1 << w) : 64'd0) | ((a - b) & mask);
        return a + b + {63'd0, cin};
    endfunction

    function automatic logic [63:0] observed(input int k);
        return s_v[k] | ({63'd0, cout_v[k]} << width_of(k));
    endfunction

    // Present a request; returns 1 time unit after the accepting edge with
    // the operand inputs scrambled (they only need to be valid at that edge).
    task automatic launch(input int k, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub);
        start_v[k] = 1'b1;
        a_v[k] = a;
        b_v[k] = b;
        cin_v[k] = cin;
        sub_v[k] = sub;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        a_v[k] = {$urandom, $urandom};
        b_v[k] = {$urandom, $urandom};
        cin_v[k] = 1'($urandom);
        sub_v[k] = 1'($urandom);
    endtask

    // Wait for done; n = edges elapsed, flags for s/cout moving or busy
    // dropping before completion.
    task automatic wait_done(input int k, output int n, output bit moved, output bit busy_gap);
        logic [63:0] hold;
        hold = observed(k);
        n = 0;
        moved = 1'b0;
        busy_gap = 1'b0;
        while (!done_v[k] && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (!done_v[k]) begin
                if (observed(k) !== hold) moved = 1'b1;
                if (!busy_v[k]) busy_gap = 1'b1;
            end
        end
        if (!done_v[k]) check("done_timeout", 64'(done_v[k]), 64'd1);
    endtask

    task automatic do_op(input int k, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub, input string tag);
        int  n;
        bit  moved, gap;
        launch(k, a, b, cin, sub);
        check({tag, "_busy_run"}, 64'(busy_v[k]), 64'd1);
        wait_done(k, n, moved, gap);
        check({tag, "_latency"}, 64'(n), 64'(width_of(k)));
        check({tag, "_result"}, observed(k), ref_result(width_of(k), a, b, cin, sub & c_SUB_EN));
        check({tag, "_stable"}, 64'(moved), 64'd0);
        check({tag, "_busy_held"}, 64'(gap), 64'd0);
        check({tag, "_busy_at_done"}, 64'(busy_v[k]), 64'd0);
    endtask

    // Count done pulses over a window while idle.
    task automatic idle_window(input int k, input int cycles, input string tag);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done_v[k] || busy_v[k]) pulses++;
        end
        check({tag, "_quiet"}, 64'(pulses), 64'd0);
    endtask

    initial begin
        int  n;
        bit  moved, gap;
        logic [63:0] ra, rb, mask, prev;

        rst_n = 1'b0;
        for (int k = 0; k < N_DUT; k++) begin
            start_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0; cin_v[k] = 1'b0; sub_v[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            check("rst_busy", 64'(busy_v[k]), 64'd0);
            check("rst_done", 64'(done_v[k]), 64'd0);
            check("rst_sum", observed(k), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic add: 0x5A + 0xA5 + 1 = 0x100
        do_op(0, 64'h5A, 64'hA5, 1'b1, 1'b0, "t1");
        check("t1_s", s_v[0], 64'h00);
        check("t1_cout", 64'(cout_v[0]), 64'd1);
        @(posedge clk); #1;
        check("t1_done_width", 64'(done_v[0]), 64'd0);
        check("t1_s_hold", s_v[0], 64'h00);

        // Back-to-back: second start issued on the DONE cycle
        do_op(0, 64'hFF, 64'h01, 1'b0, 1'b0, "t2a");
        check("t2a_s", s_v[0], 64'h00);
        launch(0, 64'h12, 64'h34, 1'b0, 1'b0);
        wait_done(0, n, moved, gap);
        check("t2b_gap9", 64'(n + 1), 64'd9);
        check("t2b_s", s_v[0], 64'h46);
        check("t2b_cout", 64'(cout_v[0]), 64'd0);
        @(posedge clk); #1;
        check("t2b_done_width", 64'(done_v[0]), 64'd0);

        // Start during RUN is ignored
        launch(0, 64'h0F, 64'h01, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        start_v[0] = 1'b1; a_v[0] = 64'hFF;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        wait_done(0, n, moved, gap);
        check("t3_latency", 64'(n + 3), 64'd8);
        check("t3_s", s_v[0], 64'h10);
        check("t3_cout", 64'(cout_v[0]), 64'd0);
        idle_window(0, 12, "t3");

        // Reset mid-run aborts and clears outputs
        launch(0, 64'h21, 64'h11, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t4_busy", 64'(busy_v[0]), 64'd0);
        check("t4_done", 64'(done_v[0]), 64'd0);
        check("t4_sum", observed(0), 64'd0);
        rst_n = 1'b1;
        idle_window(0, 12, "t4");
        do_op(0, 64'h03, 64'h04, 1'b0, 1'b0, "t4b");
        check("t4b_s", s_v[0], 64'h07);

`ifdef SERIAL_SUB_EN
        // cin is set to 1 to show it is ignored in subtract mode
        do_op(0, 64'h10, 64'h01, 1'b1, 1'b1, "t5a");
        check("t5a_s", s_v[0], 64'h0F);
        check("t5a_cout", 64'(cout_v[0]), 64'd1);
        do_op(0, 64'h01, 64'h02, 1'b0, 1'b1, "t5b");
        check("t5b_s", s_v[0], 64'hFF);
        check("t5b_cout", 64'(cout_v[0]), 64'd0);
        do_op(0, 64'h37, 64'h12, 1'b0, 1'b0, "t5c");
        check("t5c_s", s_v[0], 64'h49);
        @(posedge clk); #1;
`endif

        // Randomized sweep, mixing back-to-back and idle gaps
        for (int k = 0; k < N_DUT; k++) begin
            mask = (64'd1 << width_of(k)) - 64'd1;
            for (int i = 0; i < 1000; i++) begin
                ra = {$urandom, $urandom} & mask;
                rb = {$urandom, $urandom} & mask;
                do_op(k, ra, rb, 1'($urandom), 1'($urandom), "rnd");
                if ($urandom_range(0, 2) != 0) begin
                    prev = observed(k);
                    @(posedge clk); #1;
                    check("rnd_done_width", 64'(done_v[k]), 64'd0);
                    check("rnd_hold", observed(k), prev);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
